note_sequencer: RTL
===================

Name: note_sequencer

Overview:
- Playback-side counterpart to the pitch-to-duration path: accepts symbolic note events (tone index plus duration class) and regenerates a per-sample note-index stream at the audio frame rate.
- The stream is paced by an external sample strobe, so a downstream duration-detection stage rebuilds the same note/rest and duration flags.
- Sits between the transcription/score store and the tone synthesizer or loopback checker.
- Includes a small input FIFO so an upstream engine can queue notes ahead of playback.

Parameters:
- BPM, 60, tempo in quarter notes per minute.
- SAMPLE_RATE, 17000, note-index samples per second (rate of sample_tick).
- FIFO_DEPTH, 8, number of queued note events (power of 2, at least 2).
- GAP_SAMPLES, 64, rest samples inserted between repeated tones (only with optional feature).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous active-high reset
- sample_tick  in  1  one-cycle strobe, one per output sample period
- note_valid  in  1  upstream offers a note event
- note_tone  in  6  tone index; 0 = rest
- note_dur  in  2  0 = eighth, 1 = quarter, 2 = half, 3 = whole
- note_ready  out  1  FIFO can accept; an event transfers on note_valid & note_ready
- note_index  out  6  current sample's tone index
- note_index_ready  out  1  one-cycle strobe marking note_index valid
- playing  out  1  high while a queued note (or gap) is being emitted
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Sample counts per note:
  - Q = SAMPLE_RATE*60/BPM, computed at elaboration.
  - eighth = Q>>1, quarter = Q, half = Q<<1, whole = Q<<2.
  - Sample counter width is $clog2(4*Q+1). No runtime arithmetic beyond counter compare.
- Reset (async assert, sync deassert by the source):
  - FIFO emptied, state IDLE.
  - note_index = 0, note_index_ready = 0, playing = 0, note_ready = 0, fifo_count = 0.
  - Reset mid-note abandons the note and all queued events; no partial tail is emitted.
- note_ready is registered:
  - Equals (occupancy after this cycle's push/pop < FIFO_DEPTH).
  - Goes to 1 the first cycle after reset release.
- Transfer rules:
  - A push occurs only when note_valid & note_ready.
  - Push and pop in the same cycle is legal; occupancy is unchanged.
  - Events pushed while full are impossible because ready is low.
- States:
  - IDLE: FIFO empty and nothing playing.
    - Each sample_tick emits note_index = 0 with note_index_ready = 1 next cycle. This keeps the stream alive so downstream can terminate the last note.
    - If occupancy > 0, pop the head, load tone and count, go to PLAY. The pop takes effect on the cycle after occupancy becomes nonzero, independent of sample_tick.
  - PLAY:
    - Each sample_tick registers note_index = current tone and pulses note_index_ready in the following cycle (latency 1 clock). The counter then increments.
    - When the counter reaches the note's sample count on a tick, that tick is the note's last sample.
    - In the same cycle, pop the next event if occupancy > 0 and stay in PLAY with the counter cleared. Otherwise go to IDLE. There are zero gap ticks between back-to-back notes.
  - GAP: only with the optional feature (see below).
- Exactly N note_index_ready strobes are produced per note; no tick is skipped or duplicated at note boundaries.
- Ticks arriving faster than every 2 clocks are out of spec.
- Rests (tone 0) play like notes: N strobes of index 0.
- playing = 1 in PLAY/GAP, 0 in IDLE.
- fifo_count is registered with the same timing as note_ready.

Optional Feature:
- Macro: ARTICULATION_GAP_EN.
- Defined:
  - When the popped event's tone is nonzero and equals the previously played tone, enter GAP first.
  - GAP emits GAP_SAMPLES ticks of index 0, then PLAY for the full note count.
  - Consecutive identical notes then reach the detector as distinct notes.
- Not defined:
  - GAP state and logic are absent.
  - Repeated tones are emitted back-to-back and merge downstream.
  - GAP_SAMPLES is ignored.

Test Plan (SAMPLE_RATE = 16, BPM = 60, so Q = 16; tick every 4 clocks):
- Reset, then idle 10 ticks -> 10 strobes with note_index = 0, playing = 0, note_ready = 1 one cycle after reset release.
- Push tone 12 quarter -> exactly 16 strobes of 12, then strobes of 0; playing falls after strobe 16.
- Push tone 5 eighth, tone 0 half, tone 9 whole back-to-back -> 8×5, 32×0, 64×9 with no extra samples at boundaries.
- Hold note_valid with 12 events while playing -> note_ready falls at fifo_count = 8. The remaining events transfer as pops free slots, and all 12 play in order.
- Assert rst_in mid-half-note with 3 queued -> outputs zero asynchronously; after release, only index-0 idle strobes appear.
- Push tone 7 quarter twice, then test both builds:
  - ARTICULATION_GAP_EN defined, GAP_SAMPLES = 4 -> 16×7, 4×0, 16×7.
  - ARTICULATION_GAP_EN undefined -> 32×7 contiguous.

Source files
------------

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - queued note events replayed as a tick-paced note-index stream (optional ARTICULATION_GAP_EN)
module note_sequencer #(
  parameter int BPM         = 60,
  parameter int SAMPLE_RATE = 17000,
  parameter int FIFO_DEPTH  = 8,
  parameter int GAP_SAMPLES = 64
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          sample_tick,
  input  logic                          note_valid,
  input  logic [5:0]                    note_tone,
  input  logic [1:0]                    note_dur,
  output logic                          note_ready,
  output logic [5:0]                    note_index,
  output logic                          note_index_ready,
  output logic                          playing,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int Q    = SAMPLE_RATE * 60 / BPM;
  // counter spans the longest note and the longest gap
  localparam int SPAN = (GAP_SAMPLES > 4 * Q) ? GAP_SAMPLES : 4 * Q;
  localparam int CW   = $clog2(SPAN + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int OW   = AW + 1;

  // counter value on a note's final sample, per duration class
  localparam logic [CW-1:0] LAST_EIGHTH  = CW'((Q >> 1) - 1);
  localparam logic [CW-1:0] LAST_QUARTER = CW'(Q - 1);
  localparam logic [CW-1:0] LAST_HALF    = CW'((Q << 1) - 1);
  localparam logic [CW-1:0] LAST_WHOLE   = CW'((Q << 2) - 1);
  localparam logic [OW-1:0] DEPTH_C      = OW'(FIFO_DEPTH);

`ifdef ARTICULATION_GAP_EN
  localparam logic [CW-1:0] LAST_GAP = CW'(GAP_SAMPLES - 1);
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;
`else
  typedef enum logic {S_IDLE, S_PLAY} state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [5:0]      tone_q, tone_d;
  logic [1:0]      dur_q, dur_d;
  logic [5:0]      idx_q, idx_d;
  logic            strb_q, strb_d;
`ifdef ARTICULATION_GAP_EN
  logic [5:0]      prev_q, prev_d;
`endif

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [OW-1:0]   count_q, count_d;
  logic            ready_q, ready_d;
  logic            push, pop, load, have;
  logic [5:0]      head_tone;
  logic [1:0]      head_dur;
  logic [CW-1:0]   last_cnt;

  assign head_tone = mem[rd_q][7:2];
  assign head_dur  = mem[rd_q][1:0];
  assign have      = (count_q != '0);

  // select final-sample counter value for the note being played
  always_comb begin
    last_cnt = LAST_QUARTER;
    case (dur_q)
      2'd0:    last_cnt = LAST_EIGHTH;
      2'd1:    last_cnt = LAST_QUARTER;
      2'd2:    last_cnt = LAST_HALF;
      default: last_cnt = LAST_WHOLE;
    endcase
  end

  // FIFO occupancy next state; ready reflects occupancy after this cycle's push/pop
  always_comb begin
    push    = note_valid & ready_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + OW'(1);
    end else if (pop && !push) begin
      count_d = count_q - OW'(1);
    end
    ready_d = (count_d < DEPTH_C);
  end

  // playback FSM: next state, sample emission and head-of-queue pops
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tone_d  = tone_q;
    dur_d   = dur_q;
    idx_d   = idx_q;
    strb_d  = 1'b0;
    load    = 1'b0;
`ifdef ARTICULATION_GAP_EN
    prev_d  = prev_q;
`endif
    case (state_q)
      S_IDLE: begin
        // keep the stream alive with rests so downstream can close the last note
        if (sample_tick) begin
          idx_d  = '0;
          strb_d = 1'b1;
        end
        if (have) begin
          load = 1'b1;
        end
      end
      S_PLAY: begin
        if (sample_tick) begin
          idx_d  = tone_q;
          strb_d = 1'b1;
          if (cnt_q == last_cnt) begin
            // last sample: chain straight into the next note with no gap tick
            if (have) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef ARTICULATION_GAP_EN
      S_GAP: begin
        if (sample_tick) begin
          idx_d  = '0;
          strb_d = 1'b1;
          if (cnt_q == LAST_GAP) begin
            state_d = S_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      tone_d  = head_tone;
      dur_d   = head_dur;
      cnt_d   = '0;
      state_d = S_PLAY;
`ifdef ARTICULATION_GAP_EN
      // separate a repeated pitched tone so the detector sees two notes
      prev_d = head_tone;
      if ((head_tone != 6'd0) && (head_tone == prev_q)) begin
        state_d = S_GAP;
      end
`endif
    end
    pop = load;
  end

  // playback registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tone_q  <= '0;
      dur_q   <= '0;
      idx_q   <= '0;
      strb_q  <= 1'b0;
`ifdef ARTICULATION_GAP_EN
      prev_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tone_q  <= tone_d;
      dur_q   <= dur_d;
      idx_q   <= idx_d;
      strb_q  <= strb_d;
`ifdef ARTICULATION_GAP_EN
      prev_q  <= prev_d;
`endif
    end
  end

  // FIFO storage; entries are only read while occupied, so no reset needed
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_q] <= {note_tone, note_dur};
    end
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  assign note_ready       = ready_q;
  assign fifo_count       = count_q;
  assign note_index       = idx_q;
  assign note_index_ready = strb_q;
  assign playing          = (state_q != S_IDLE);

endmodule
